// File: rtl/lr_coef_if.sv
// Sample/coefficient bus for the least-squares coefficient estimator.
// The master side drives start and the sample stream. The slave side
// (the estimator) returns status and the B0/B1 coefficients.
interface lr_coef_if;
  logic        start;
  logic        in_valid;
  logic [19:0] x_in;
  logic [19:0] y_in;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [19:0] B0;
  logic [19:0] B1;
  logic        degen;

  modport master (output start, in_valid, x_in, y_in,
                  input  in_ready, busy, done, B0, B1, degen);
  modport slave  (input  start, in_valid, x_in, y_in,
                  output in_ready, busy, done, B0, B1, degen);
endinterface

// File: rtl/lr_coef_estimator.sv
// Least-squares intercept/slope estimator over a batch of SAMPLE_CNT Q10.10
// (x, y) pairs. It accumulates the sums, forms num/den in one cycle, then
// runs one shared restoring divider twice: first for the slope, then for
// the intercept. Accumulator widths cover SAMPLE_CNT=255 at full-scale input.
module lr_coef_estimator #(
  parameter int SAMPLE_CNT = 150,
  parameter int DIV_W      = 80
) (
  input  logic       clk,
  input  logic       reset,
  lr_coef_if.slave   bus
);
  localparam int SX_W = 28;               // 255 * 2^19 < 2^27
  localparam int SQ_W = 48;               // 255 * 2^38 < 2^46
  localparam int ND_W = 58;               // n*sxy and sx*sy are each < 2^54
  localparam int T_W  = 48;               // sy - (B1*sx >>> 10)
  localparam int DC_W = $clog2(DIV_W);
  localparam logic signed [9:0] N_S = 10'(SAMPLE_CNT);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_CALC, S_DIV1, S_PRE2, S_DIV2, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               smp_cnt_q, smp_cnt_d;
  logic [DC_W-1:0]          div_cnt_q, div_cnt_d;
  logic signed [SX_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic signed [SQ_W-1:0]   sxx_q, sxx_d, sxy_q, sxy_d;
  logic [DIV_W-1:0]         dq_q, dq_d;     // dividend in, quotient out
  logic [ND_W-1:0]          rem_q, rem_d;
  logic [ND_W-1:0]          dvs_q, dvs_d;
  logic                     neg_q, neg_d;
  logic signed [19:0]       b1_res_q, b1_res_d;
  logic                     degen_res_q, degen_res_d;
  logic [19:0]              b0_q, b0_d, b1_q, b1_d;
  logic                     degen_q, degen_d;

  logic signed [19:0]       x_s, y_s;
  logic signed [39:0]       prod_xx, prod_xy;
  logic signed [ND_W-1:0]   num, den;
  logic [ND_W-1:0]          num_mag, den_mag;
  logic signed [T_W-1:0]    b1p, t;
  logic [T_W-1:0]           t_mag;
  logic [ND_W:0]            rem_sh;
  logic                     ge;
  logic [ND_W-1:0]          rem_nx;
  logic [DIV_W-1:0]         dq_nx;
  logic                     div_last;

  // Truncated quotient magnitude plus sign, clamped to signed 20 bits.
  function automatic logic [19:0] sat20(input logic [DIV_W-1:0] m, input logic ng);
    logic [19:0] r;
    if (ng) r = (m > DIV_W'(32'h80000)) ? 20'h80000 : 20'(-m);
    else    r = (m > DIV_W'(32'h7FFFF)) ? 20'h7FFFF : 20'(m);
    return r;
  endfunction

  // Datapath: sample products, CALC terms, PRE2 term, one divider step.
  always_comb begin
    x_s     = bus.x_in;
    y_s     = bus.y_in;
    prod_xx = 40'(x_s) * 40'(x_s);
    prod_xy = 40'(x_s) * 40'(y_s);
    num     = ND_W'(N_S) * ND_W'(sxy_q) - ND_W'(sx_q) * ND_W'(sy_q);
    den     = ND_W'(N_S) * ND_W'(sxx_q) - ND_W'(sx_q) * ND_W'(sx_q);
    num_mag = num[ND_W-1] ? -num : num;
    den_mag = den[ND_W-1] ? -den : den;
    b1p     = T_W'(b1_res_q) * T_W'(sx_q);
    t       = T_W'(sy_q) - (b1p >>> 10);
    t_mag   = t[T_W-1] ? -t : t;
    // Restoring step: bring in the next dividend bit and subtract if it fits.
    rem_sh  = {rem_q, dq_q[DIV_W-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_nx  = ge ? ND_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[ND_W-1:0];
    dq_nx   = {dq_q[DIV_W-2:0], ge};
    div_last = (div_cnt_q == DC_W'(DIV_W - 1));
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    div_cnt_d   = div_cnt_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    sxx_d       = sxx_q;
    sxy_d       = sxy_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    b1_res_d    = b1_res_q;
    degen_res_d = degen_res_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    degen_d     = degen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          sx_d      = '0;
          sy_d      = '0;
          sxx_d     = '0;
          sxy_d     = '0;
          smp_cnt_d = '0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          sx_d      = sx_q + SX_W'(x_s);
          sy_d      = sy_q + SX_W'(y_s);
          sxx_d     = sxx_q + SQ_W'(prod_xx);
          sxy_d     = sxy_q + SQ_W'(prod_xy);
          smp_cnt_d = smp_cnt_q + 8'd1;
          if (smp_cnt_q == 8'(SAMPLE_CNT - 1)) state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Slope quotient carries 10 fraction bits: (num << 10) / den.
        dq_d        = DIV_W'({num_mag, 10'b0});
        rem_d       = '0;
        dvs_d       = den_mag;
        neg_d       = num[ND_W-1] ^ den[ND_W-1];
        degen_res_d = (den == '0);
        div_cnt_d   = '0;
        state_d     = S_DIV1;
      end
      S_DIV1: begin
        dq_d      = dq_nx;
        rem_d     = rem_nx;
        div_cnt_d = div_cnt_q + DC_W'(1);
        if (div_last) begin
          // Zero variance: the divider still runs its full length, result dropped.
          b1_res_d = degen_res_q ? 20'sd0 : sat20(dq_nx, neg_q);
          state_d  = S_PRE2;
        end
      end
      S_PRE2: begin
        dq_d      = DIV_W'(t_mag);
        rem_d     = '0;
        dvs_d     = ND_W'(SAMPLE_CNT);
        neg_d     = t[T_W-1];
        div_cnt_d = '0;
        state_d   = S_DIV2;
      end
      S_DIV2: begin
        dq_d      = dq_nx;
        rem_d     = rem_nx;
        div_cnt_d = div_cnt_q + DC_W'(1);
        if (div_last) begin
          // Outputs update together so they are all valid while done is high.
          b0_d    = sat20(dq_nx, neg_q);
          b1_d    = b1_res_q;
          degen_d = degen_res_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any batch in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      smp_cnt_q   <= '0;
      div_cnt_q   <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      sxx_q       <= '0;
      sxy_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      b1_res_q    <= '0;
      degen_res_q <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      degen_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      div_cnt_q   <= div_cnt_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sxx_q       <= sxx_d;
      sxy_q       <= sxy_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      b1_res_q    <= b1_res_d;
      degen_res_q <= degen_res_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      degen_q     <= degen_d;
    end
  end

  assign bus.in_ready = (state_q == S_ACCUM);
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.B0       = b0_q;
  assign bus.B1       = b1_q;
  assign bus.degen    = degen_q;
endmodule

// File: tb/tb_lr_coef_estimator.sv
// Directed bench for lr_coef_estimator: a 4-sample instance for the small
// hand-worked batches and a default 150-sample instance for full-scale input.
module tb_lr_coef_estimator;
  localparam int DIV_W = 80;
  localparam int LAT   = 2 * DIV_W + 3;

  logic clk = 1'b0;
  logic reset;
  logic start4, start150, in_valid;
  logic [19:0] x, y;
  bit   sel;
  int   checks = 0;
  int   failures = 0;
  logic [19:0] vx[150];
  logic [19:0] vy[150];

  always #5 clk = ~clk;

  lr_coef_if if4();
  lr_coef_if if150();

  assign if4.start      = start4;
  assign if4.in_valid   = in_valid;
  assign if4.x_in       = x;
  assign if4.y_in       = y;
  assign if150.start    = start150;
  assign if150.in_valid = in_valid;
  assign if150.x_in     = x;
  assign if150.y_in     = y;

  lr_coef_estimator #(.SAMPLE_CNT(4), .DIV_W(DIV_W)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave));
  lr_coef_estimator #(.SAMPLE_CNT(150), .DIV_W(DIV_W)) u_dut150 (
    .clk(clk), .reset(reset), .bus(if150.slave));

  wire        done_s  = sel ? if150.done     : if4.done;
  wire        busy_s  = sel ? if150.busy     : if4.busy;
  wire        rdy_s   = sel ? if150.in_ready : if4.in_ready;
  wire [19:0] b0_s    = sel ? if150.B0       : if4.B0;
  wire [19:0] b1_s    = sel ? if150.B1       : if4.B1;
  wire        degen_s = sel ? if150.degen    : if4.degen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    if (sel) start150 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start150 = 1'b0;
  endtask

  // Send n samples; gap idle cycles between samples carry junk data, and
  // stray raises start during a gap while the batch is accumulating.
  task automatic send(input int n, input int gap, input bit stray);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      x = vx[i];
      y = vy[i];
      @(negedge clk);
      in_valid = 1'b0;
      x = 20'hABCDE;
      y = 20'h54321;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start4 = (stray && g == 1);
          @(negedge clk);
        end
        start4 = 1'b0;
      end
    end
  endtask

  // Called at the negedge right after the accepting edge (cycle 1 = CALC).
  task automatic wait_done(input string tag, input bit stray_div, input bit chain);
    int lat;
    int extra;
    lat = 1;
    extra = 0;
    chk({tag, "_calc_busy"}, busy_s, 1);
    chk({tag, "_calc_rdy"}, rdy_s, 0);
    while (done_s !== 1'b1 && lat < 400) begin
      start4 = (stray_div && lat == 20);
      @(negedge clk);
      lat++;
    end
    start4 = 1'b0;
    chk({tag, "_latency"}, lat, LAT);
    if (chain) begin
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk({tag, "_restart_rdy"}, rdy_s, 1);
    end else begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done_s) extra++;
      end
      chk({tag, "_single_done"}, extra, 0);
      chk({tag, "_idle_busy"}, busy_s, 0);
    end
  endtask

  task automatic chk_out(input string tag, input logic [19:0] b1, input logic [19:0] b0,
                         input logic dg);
    chk({tag, "_B1"}, b1_s, b1);
    chk({tag, "_B0"}, b0_s, b0);
    chk({tag, "_degen"}, degen_s, dg);
  endtask

  task automatic load(input logic [19:0] x0, x1, x2, x3, y0, y1, y2, y3);
    vx[0] = x0; vx[1] = x1; vx[2] = x2; vx[3] = x3;
    vy[0] = y0; vy[1] = y1; vy[2] = y2; vy[3] = y3;
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0;
    start150 = 1'b0;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk_out("rst", 20'h0, 20'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Case 1: y = 2x + 1
    load(20'h00400, 20'h00800, 20'h00C00, 20'h01000,
         20'h00C00, 20'h01400, 20'h01C00, 20'h02400);
    do_start();
    send(4, 0, 1'b0);
    wait_done("c1", 1'b0, 1'b0);
    chk_out("c1", 20'h00800, 20'h00400, 1'b0);

    // Case 2: y = -x + 5
    load(20'h00400, 20'h00800, 20'h00C00, 20'h01000,
         20'h01000, 20'h00C00, 20'h00800, 20'h00400);
    do_start();
    send(4, 0, 1'b0);
    wait_done("c2", 1'b0, 1'b0);
    chk_out("c2", 20'hFFC00, 20'h01400, 1'b0);

    // Case 3: constant x, so zero variance; B0 = mean(y) = 2.5; restart from DONE
    load(20'h00800, 20'h00800, 20'h00800, 20'h00800,
         20'h00400, 20'h00800, 20'h00C00, 20'h01000);
    do_start();
    send(4, 0, 1'b0);
    wait_done("c3", 1'b0, 1'b1);
    chk_out("c3", 20'h00000, 20'h00A00, 1'b1);

    // Case 4: case 1 with gaps and stray starts in ACCUM and DIV1
    load(20'h00400, 20'h00800, 20'h00C00, 20'h01000,
         20'h00C00, 20'h01400, 20'h01C00, 20'h02400);
    send(4, 3, 1'b1);
    wait_done("c4", 1'b1, 1'b0);
    chk_out("c4", 20'h00800, 20'h00400, 1'b0);

    // Case 5: reset in the middle of DIV1, then case 2
    do_start();
    send(4, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("c5_pre_busy", busy_s, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("c5_rst_busy", busy_s, 0);
    chk("c5_rst_rdy", rdy_s, 0);
    chk("c5_rst_done", done_s, 0);
    chk_out("c5_rst", 20'h0, 20'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("c5_idle_busy", busy_s, 0);
    load(20'h00400, 20'h00800, 20'h00C00, 20'h01000,
         20'h01000, 20'h00C00, 20'h00800, 20'h00400);
    do_start();
    send(4, 0, 1'b0);
    wait_done("c5", 1'b0, 1'b0);
    chk_out("c5", 20'hFFC00, 20'h01400, 1'b0);

    // Case 6: 150 full-scale samples, x = +/-0x7FFFF, y = (x >>> 1) + 3.0.
    // Exact slope 0.5; intercept 460725/150 = 3071.5 raw, truncated to 0xBFF.
    sel = 1'b1;
    for (int i = 0; i < 150; i++) begin
      vx[i] = (i % 2 == 0) ? 20'h7FFFF : 20'h80001;
      vy[i] = (i % 2 == 0) ? 20'h40BFF : 20'hC0C00;
    end
    do_start();
    send(150, 0, 1'b0);
    wait_done("c6", 1'b0, 1'b0);
    chk_out("c6", 20'h00200, 20'h00BFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
